// File: rtl/dom_pkg.sv
// dom_pkg: constants and helpers shared by the DOM-indep masked GF(2^N)
// multiplier and its sub-modules.
//   dom_state_e : valid-tracking FSM states for the non-pipelined variant
//   num_pairs   : number of share pairs (i<j), i.e. number of fresh Z words
//   pair_idx    : lexicographic index k of pair (i,j), i<j
//   share_width : bit width of a packed sharing
//   gf_poly     : reduction polynomial (with leading term) used by gf2_mul
package dom_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    PHASE1 = 1'b1
  } dom_state_e;

  function automatic int num_pairs(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // Pairs before row i: sum_{a<i}(shares-1-a) = i*(2*shares-i-1)/2.
  function automatic int pair_idx(input int i, input int j, input int shares);
    return (i * (2 * shares - i - 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int share_width(input int shares, input int n);
    return shares * n;
  endfunction

  // Polynomial-basis reduction polynomials (irreducible).
  function automatic int gf_poly(input int n);
    case (n)
      2:       return 32'h007;  // x^2+x+1
      3:       return 32'h00B;  // x^3+x+1
      4:       return 32'h013;  // x^4+x+1
      5:       return 32'h025;  // x^5+x^2+1
      6:       return 32'h043;  // x^6+x+1
      7:       return 32'h083;  // x^7+x+1
      8:       return 32'h11B;  // x^8+x^4+x^3+x+1
      default: return 32'h007;
    endcase
  endfunction

endpackage

// File: rtl/dom_valid_ctrl.sv
// dom_valid_ctrl: valid tracking through the multiplier's register stage.
//   PIPELINED=1 : single valid register, ValidxSO = registered ValidxSI
//   PIPELINED=0 : IDLE/PHASE1 FSM, ValidxSO = PHASE1 & ValidxSI (inputs held
//                 two enabled cycles; dropping ValidxSI in PHASE1 aborts)
//   ClkxCI, RstxBI (async, active-low), EnxSI (stage enable), ValidxSI in,
//   ValidxSO out
module dom_valid_ctrl
  import dom_pkg::*;
#(
  parameter bit PIPELINED = 1'b1
) (
  input  logic ClkxCI,
  input  logic RstxBI,
  input  logic EnxSI,
  input  logic ValidxSI,
  output logic ValidxSO
);

  if (PIPELINED) begin : g_pipe
    logic valid_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI)    valid_q <= 1'b0;
      else if (EnxSI) valid_q <= ValidxSI;
    end

    assign ValidxSO = valid_q;
  end else begin : g_fsm
    dom_state_e state_q, state_d;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) state_q <= IDLE;
      else         state_q <= state_d;
    end

    // PHASE1 always lasts exactly one enabled cycle, valid or not.
    always_comb begin
      state_d = state_q;
      if (EnxSI) begin
        case (state_q)
          IDLE:    if (ValidxSI) state_d = PHASE1;
          PHASE1:  state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    // Gating with the live ValidxSI makes an aborted hold produce nothing.
    always_comb begin
      ValidxSO = (state_q == PHASE1) & ValidxSI;
    end
  end

endmodule

// File: rtl/gf2_mul.sv
// gf2_mul: combinational GF(2^N) multiplier, polynomial basis, reduction
// polynomial from dom_pkg::gf_poly.
//   a_i, b_i : field operands
//   p_o      : a_i * b_i
module gf2_mul
  import dom_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  localparam int           POLY    = gf_poly(N);
  localparam logic [N-1:0] POLY_LO = POLY[N-1:0];

  logic [N-1:0] acc;
  logic [N-1:0] sh;

  // Shift-and-add: sh walks through a*x^b reduced on the fly.
  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int b = 0; b < N; b++) begin
      if (b_i[b]) acc = acc ^ sh;
      sh = sh[N-1] ? ({sh[N-2:0], 1'b0} ^ POLY_LO) : {sh[N-2:0], 1'b0};
    end
    p_o = acc;
  end

endmodule

// File: rtl/dom_shared_mul_gf2n.sv
// dom_shared_mul_gf2n: DOM-indep masked GF(2^N) multiplier, SHARES shares.
//   ClkxCI   : clock, rising edge
//   RstxBI   : asynchronous active-low reset
//   EnxSI    : stage enable, low freezes all registers
//   ValidxSI : input transaction valid
//   _XxDI    : X sharing, share i at [i*N +: N]
//   _YxDI    : Y sharing, same packing
//   _ZxDI    : fresh randomness, pair k at [k*N +: N]
//   ValidxSO : output valid
//   _QxDO    : product sharing, zero when ValidxSO=0
module dom_shared_mul_gf2n
  import dom_pkg::*;
#(
  parameter int N         = 2,
  parameter int SHARES    = 2,
  parameter bit PIPELINED = 1'b1
) (
  input  logic                               ClkxCI,
  input  logic                               RstxBI,
  input  logic                               EnxSI,
  input  logic                               ValidxSI,
  input  logic [share_width(SHARES, N)-1:0]  _XxDI,
  input  logic [share_width(SHARES, N)-1:0]  _YxDI,
  input  logic [num_pairs(SHARES)*N-1:0]     _ZxDI,
  output logic                               ValidxSO,
  output logic [share_width(SHARES, N)-1:0]  _QxDO
);

  localparam int W  = share_width(SHARES, N);
  localparam int PW = SHARES * SHARES * N;

  logic [W-1:0]  x_op, y_op;     // operands of the inner (same-domain) terms
  logic [PW-1:0] prod;           // all x_i*y_j, entry (i,j) at (i*SHARES+j)*N
  logic [PW-1:0] cross_d;        // diagonal entries are constant zero
  logic [PW-1:0] cross_q;
  logic [W-1:0]  q_raw;

  if (PIPELINED) begin : g_xy_reg
    logic [W-1:0] x_q, y_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        x_q <= '0;
        y_q <= '0;
      end else if (EnxSI) begin
        x_q <= _XxDI;
        y_q <= _YxDI;
      end
    end

    assign x_op = x_q;
    assign y_op = y_q;
  end else begin : g_xy_comb
    assign x_op = _XxDI;
    assign y_op = _YxDI;
  end

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
      localparam int IDX = gi * SHARES + gj;

      if (gi == gj) begin : g_inner
        gf2_mul #(.N(N)) u_mul (
          .a_i (x_op[gi*N +: N]),
          .b_i (y_op[gi*N +: N]),
          .p_o (prod[IDX*N +: N])
        );
        assign cross_d[IDX*N +: N] = '0;
      end else begin : g_cross
        // Both (i,j) and (j,i) consume the same Z word, so it cancels in
        // the recombined product.
        localparam int K = (gi < gj) ? pair_idx(gi, gj, SHARES)
                                     : pair_idx(gj, gi, SHARES);
        gf2_mul #(.N(N)) u_mul (
          .a_i (_XxDI[gi*N +: N]),
          .b_i (_YxDI[gj*N +: N]),
          .p_o (prod[IDX*N +: N])
        );
        assign cross_d[IDX*N +: N] = prod[IDX*N +: N] ^ _ZxDI[K*N +: N];
      end
    end
  end

  // Cross terms are registered on every enabled edge so no path from Z
  // reaches the outputs combinationally.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI)    cross_q <= '0;
    else if (EnxSI) cross_q <= cross_d;
  end

  dom_valid_ctrl #(.PIPELINED(PIPELINED)) u_valid (
    .ClkxCI   (ClkxCI),
    .RstxBI   (RstxBI),
    .EnxSI    (EnxSI),
    .ValidxSI (ValidxSI),
    .ValidxSO (ValidxSO)
  );

  // Row i XORs its whole cross_q row; the diagonal entry is always zero.
  always_comb begin
    q_raw = '0;
    for (int i = 0; i < SHARES; i++) begin
      q_raw[i*N +: N] = prod[(i*SHARES+i)*N +: N];
      for (int j = 0; j < SHARES; j++) begin
        q_raw[i*N +: N] = q_raw[i*N +: N] ^ cross_q[(i*SHARES+j)*N +: N];
      end
    end
  end

  assign _QxDO = {W{ValidxSO}} & q_raw;

endmodule
